uart_tx_frame: RTL and testbench



---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_tx_frame_if.sv | 30 +++
 rtl/uart_tx_serializer.sv | 58 +++++
 rtl/uart_tx_frame.sv | 139 +++++++++++++
 tb/tb_uart_tx_frame.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity and line-level constants, small helpers.
// Used by both the transmit and receive sides of the link.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   localparam logic PAR_EVEN  = 1'b0;
   localparam logic PAR_ODD   = 1'b1;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;

   // Bit-index width for a payload of dw bits; never narrower than one bit.
   function automatic int cnt_width(input int dw);
      return (dw > 1) ? $clog2(dw) : 1;
   endfunction

   // data_xor is the XOR of all payload bits; odd parity inverts it.
   function automatic logic parity_bit(input logic data_xor, input logic par_typ);
      return (par_typ == PAR_ODD) ? ~data_xor : data_xor;
   endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Parallel request side and serial/status outputs of the UART transmitter.
// master = upstream register/FIFO side, slave = uart_tx_frame.
interface uart_tx_frame_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  Data_Valid;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic                  TX_OUT;
   logic                  Busy;

   modport master (
      output P_DATA,
      output Data_Valid,
      output PAR_EN,
      output PAR_TYP,
      input  TX_OUT,
      input  Busy
   );

   modport slave (
      input  P_DATA,
      input  Data_Valid,
      input  PAR_EN,
      input  PAR_TYP,
      output TX_OUT,
      output Busy
   );
endinterface

// File: rtl/uart_tx_serializer.sv
// Payload holding register and bit index for the UART transmitter.
// ser_bit is the payload bit for the index the counter holds after this edge.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  clear,
   input  logic                  step,
   output logic                  ser_bit,
   output logic                  ser_done,
   output logic [DATA_WIDTH-1:0] data
);
   localparam int CNT_W = cnt_width(DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] data_reg;
   logic [CNT_W-1:0]      cnt_reg;
   logic [CNT_W-1:0]      cnt_next;
   logic [DATA_WIDTH-1:0] sel_vec;

   // Counter saturates at the last payload bit rather than wrapping.
   always_comb begin
      cnt_next = cnt_reg;
      if (clear) begin
         cnt_next = '0;
      end else if (step && (cnt_reg != CNT_LAST)) begin
         cnt_next = cnt_reg + CNT_W'(1);
      end
   end

   // One-hot select keeps the mux free of out-of-range indices for any width.
   generate
      for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_sel
         assign sel_vec[gi] = data_reg[gi] & (cnt_next == CNT_W'(gi));
      end
   endgenerate

   assign ser_bit  = |sel_vec;
   assign ser_done = (cnt_reg == CNT_LAST);
   assign data     = data_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_reg <= '0;
         cnt_reg  <= '0;
      end else begin
         if (load) begin
            data_reg <= load_data;
         end
         cnt_reg <= cnt_next;
      end
   end
endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter clocked at the bit rate: start, DATA_WIDTH bits LSB first, optional parity, stop.
// Define UART_TX_TWO_STOP_EN for two stop bits; the default build sends a single stop bit.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
)(
   input  logic           CLK,
   input  logic           Reset,
   uart_tx_frame_if.slave bus
);
   uart_state_e           state_reg;
   uart_state_e           state_next;
   logic                  tx_reg;
   logic                  tx_next;
   logic                  busy_reg;
   logic                  busy_next;
   logic                  par_en_reg;
   logic                  par_typ_reg;
   logic                  accept;
   logic                  ser_clear;
   logic                  ser_step;
   logic                  ser_bit;
   logic                  ser_done;
   logic                  parity_val;
   logic                  stop_last;
   logic [DATA_WIDTH-1:0] ser_data;

`ifdef UART_TX_TWO_STOP_EN
   logic stop_cnt_reg;
   logic stop_cnt_next;

   // First STOP cycle arms the counter; the second one may accept a new request.
   assign stop_cnt_next = (state_reg == STOP) && !stop_cnt_reg;
   assign stop_last     = stop_cnt_reg;

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         stop_cnt_reg <= 1'b0;
      end else begin
         stop_cnt_reg <= stop_cnt_next;
      end
   end
`else
   assign stop_last = 1'b1;
`endif

   uart_tx_serializer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_serializer (
      .clk       (CLK),
      .rst_n     (Reset),
      .load      (accept),
      .load_data (bus.P_DATA),
      .clear     (ser_clear),
      .step      (ser_step),
      .ser_bit   (ser_bit),
      .ser_done  (ser_done),
      .data      (ser_data)
   );

   // Parity always comes from the captured payload, never the live bus.
   assign parity_val = parity_bit(^ser_data, par_typ_reg);

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      ser_clear  = 1'b0;
      ser_step   = 1'b0;
      tx_next    = LINE_IDLE;
      busy_next  = 1'b0;

      case (state_reg)
         IDLE: begin
            if (bus.Data_Valid) begin
               accept     = 1'b1;
               state_next = START;
            end
         end
         START: begin
            ser_clear  = 1'b1;
            state_next = DATA;
         end
         DATA: begin
            if (ser_done) begin
               state_next = par_en_reg ? PARITY : STOP;
            end else begin
               ser_step = 1'b1;
            end
         end
         PARITY: begin
            state_next = STOP;
         end
         STOP: begin
            if (stop_last) begin
               if (bus.Data_Valid) begin
                  accept     = 1'b1;
                  state_next = START;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Outputs are computed for the state being entered so they leave straight from flops.
      case (state_next)
         START:   tx_next = START_BIT;
         DATA:    tx_next = ser_bit;
         PARITY:  tx_next = parity_val;
         default: tx_next = LINE_IDLE;
      endcase
      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_reg   <= IDLE;
         tx_reg      <= LINE_IDLE;
         busy_reg    <= 1'b0;
         par_en_reg  <= 1'b0;
         par_typ_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         tx_reg    <= tx_next;
         busy_reg  <= busy_next;
         if (accept) begin
            par_en_reg  <= bus.PAR_EN;
            par_typ_reg <= bus.PAR_TYP;
         end
      end
   end

   assign bus.TX_OUT = tx_reg;
   assign bus.Busy   = busy_reg;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed self-checking bench for uart_tx_frame; expected line sequences are written out by hand,
// first transmitted bit leftmost. Extra stop cycle is expected when UART_TX_TWO_STOP_EN is defined.
module tb_uart_tx_frame;
   import uart_pkg::*;

   localparam int DW = 8;
`ifdef UART_TX_TWO_STOP_EN
   localparam int EXTRA_STOP = 1;
`else
   localparam int EXTRA_STOP = 0;
`endif

   logic CLK   = 1'b0;
   logic Reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   uart_tx_frame_if #(.DATA_WIDTH(DW)) bus ();

   uart_tx_frame #(
      .DATA_WIDTH (DW)
   ) dut (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic request(input logic [DW-1:0] d, input logic pe, input logic pt);
      bus.P_DATA     = d;
      bus.PAR_EN     = pe;
      bus.PAR_TYP    = pt;
      bus.Data_Valid = 1'b1;
   endtask

   task automatic test_reset();
      Reset = 1'b0;
      repeat (3) @(negedge CLK);
      checks++;
      if (bus.TX_OUT !== 1'b1) begin
         errors++;
         $display("FAIL reset_tx: TX_OUT=%b expected 1", bus.TX_OUT);
      end
      checks++;
      if (bus.Busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: Busy=%b expected 0", bus.Busy);
      end
      Reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         checks++;
         if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL idle cycle %0d: TX_OUT=%b Busy=%b expected 1/0", i, bus.TX_OUT, bus.Busy);
         end
      end
      $display("reset/idle: 20 idle cycles observed");
   endtask

   task automatic test_no_parity();
      logic [9:0] seq;
      logic       want;
      seq = 10'b0101001011;
      @(negedge CLK);
      request(8'hA5, 1'b0, PAR_EVEN);
      for (int j = 0; j < 10 + EXTRA_STOP; j++) begin
         @(negedge CLK);
         bus.Data_Valid = 1'b0;
         want = (j < 10) ? seq[9 - j] : 1'b1;
         checks++;
         if (bus.TX_OUT !== want) begin
            errors++;
            $display("FAIL no_parity bit %0d: TX_OUT=%b expected %b", j, bus.TX_OUT, want);
         end
         checks++;
         if (bus.Busy !== 1'b1) begin
            errors++;
            $display("FAIL no_parity busy %0d: Busy=%b expected 1", j, bus.Busy);
         end
      end
      @(negedge CLK);
      checks++;
      if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
         errors++;
         $display("FAIL no_parity end: TX_OUT=%b Busy=%b expected 1/0", bus.TX_OUT, bus.Busy);
      end
      $display("frame 0xA5 no parity: sent");
   endtask

   task automatic test_parity();
      logic [7:0]  dat [3];
      logic        typ [3];
      logic [10:0] seq [3];
      logic        want;
      dat[0] = 8'hA5; typ[0] = PAR_EVEN; seq[0] = 11'b01010010101;
      dat[1] = 8'hA5; typ[1] = PAR_ODD;  seq[1] = 11'b01010010111;
      dat[2] = 8'h01; typ[2] = PAR_EVEN; seq[2] = 11'b01000000011;
      for (int f = 0; f < 3; f++) begin
         request(dat[f], 1'b1, typ[f]);
         for (int j = 0; j < 11 + EXTRA_STOP; j++) begin
            @(negedge CLK);
            bus.Data_Valid = 1'b0;
            want = (j < 11) ? seq[f][10 - j] : 1'b1;
            checks++;
            if (bus.TX_OUT !== want || bus.Busy !== 1'b1) begin
               errors++;
               $display("FAIL parity frame %0d bit %0d: TX_OUT=%b Busy=%b expected %b/1",
                        f, j, bus.TX_OUT, bus.Busy, want);
            end
         end
         @(negedge CLK);
         checks++;
         if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL parity frame %0d end: TX_OUT=%b Busy=%b expected 1/0", f, bus.TX_OUT, bus.Busy);
         end
         $display("frame 0x%02h parity typ %0d: sent", dat[f], typ[f]);
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] seq [2];
      logic       want;
      seq[0] = 10'b0001111001;
      seq[1] = 10'b0110000111;
      request(8'h3C, 1'b0, PAR_EVEN);
      for (int f = 0; f < 2; f++) begin
         for (int j = 0; j < 10 + EXTRA_STOP; j++) begin
            @(negedge CLK);
            if (f == 0 && j == 1) bus.P_DATA = 8'hC3;
            if (f == 1 && j == 0) bus.Data_Valid = 1'b0;
            want = (j < 10) ? seq[f][9 - j] : 1'b1;
            checks++;
            if (bus.TX_OUT !== want) begin
               errors++;
               $display("FAIL b2b frame %0d bit %0d: TX_OUT=%b expected %b", f, j, bus.TX_OUT, want);
            end
            checks++;
            if (bus.Busy !== 1'b1) begin
               errors++;
               $display("FAIL b2b busy frame %0d bit %0d: Busy=%b expected 1", f, j, bus.Busy);
            end
         end
      end
      @(negedge CLK);
      checks++;
      if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b end: TX_OUT=%b Busy=%b expected 1/0", bus.TX_OUT, bus.Busy);
      end
      $display("back-to-back 0x3C,0xC3: sent");
   endtask

   task automatic test_mid_frame_change();
      logic [9:0] seq;
      logic       want;
      seq = 10'b0000000001;
      request(8'h00, 1'b0, PAR_EVEN);
      for (int j = 0; j < 10 + EXTRA_STOP; j++) begin
         @(negedge CLK);
         if (j == 0) bus.Data_Valid = 1'b0;
         if (j == 3) begin
            bus.P_DATA  = 8'hFF;
            bus.PAR_EN  = 1'b1;
            bus.PAR_TYP = PAR_ODD;
         end
         want = (j < 10) ? seq[9 - j] : 1'b1;
         checks++;
         if (bus.TX_OUT !== want || bus.Busy !== 1'b1) begin
            errors++;
            $display("FAIL midchange bit %0d: TX_OUT=%b Busy=%b expected %b/1", j, bus.TX_OUT, bus.Busy, want);
         end
      end
      @(negedge CLK);
      checks++;
      if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
         errors++;
         $display("FAIL midchange length: TX_OUT=%b Busy=%b expected 1/0", bus.TX_OUT, bus.Busy);
      end
      bus.PAR_EN = 1'b0;
      $display("frame 0x00 with mid-frame input changes: sent");
   endtask

   task automatic test_reset_mid_frame();
      logic [9:0] seq_a;
      logic [9:0] seq_b;
      logic       want;
      seq_a = 10'b0000011111;
      seq_b = 10'b0101010101;
      request(8'hF0, 1'b0, PAR_EVEN);
      for (int j = 0; j < 6; j++) begin
         @(negedge CLK);
         bus.Data_Valid = 1'b0;
         checks++;
         if (bus.TX_OUT !== seq_a[9 - j]) begin
            errors++;
            $display("FAIL pre_reset bit %0d: TX_OUT=%b expected %b", j, bus.TX_OUT, seq_a[9 - j]);
         end
      end
      #2 Reset = 1'b0;
      #1;
      checks++;
      if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: TX_OUT=%b Busy=%b expected 1/0", bus.TX_OUT, bus.Busy);
      end
      @(negedge CLK);
      Reset = 1'b1;
      @(negedge CLK);
      checks++;
      if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset idle: TX_OUT=%b Busy=%b expected 1/0", bus.TX_OUT, bus.Busy);
      end
      request(8'h55, 1'b0, PAR_EVEN);
      for (int j = 0; j < 10 + EXTRA_STOP; j++) begin
         @(negedge CLK);
         bus.Data_Valid = 1'b0;
         want = (j < 10) ? seq_b[9 - j] : 1'b1;
         checks++;
         if (bus.TX_OUT !== want || bus.Busy !== 1'b1) begin
            errors++;
            $display("FAIL after_reset bit %0d: TX_OUT=%b Busy=%b expected %b/1", j, bus.TX_OUT, bus.Busy, want);
         end
      end
      @(negedge CLK);
      checks++;
      if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
         errors++;
         $display("FAIL after_reset end: TX_OUT=%b Busy=%b expected 1/0", bus.TX_OUT, bus.Busy);
      end
      $display("reset mid-frame then frame 0x55: sent");
   endtask

   initial begin
      bus.P_DATA     = '0;
      bus.Data_Valid = 1'b0;
      bus.PAR_EN     = 1'b0;
      bus.PAR_TYP    = PAR_EVEN;
      test_reset();
      test_no_parity();
      test_parity();
      test_back_to_back();
      test_mid_frame_change();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
